// File: rtl/rv32im_wb_arbiter_pkg.sv
// Shared Wishbone definitions and arbiter FSM encodings for the RV32IM
// fetch / data-memory bus arbiter.
package rv32im_wb_arbiter_pkg;

  // Wishbone byte-select width for a 32-bit data path.
  localparam int WB_SEL_W = 4;

  // Default number of granted cycles without ack/err before a forced error.
  localparam int WB_TIMEOUT_DEFAULT = 255;

  // Value of the "last served" marker after reset: 1 means m1 was served
  // last, so m0 wins the first tie.
  localparam logic WB_LAST_RESET = 1'b1;

  // Encodings double as the one-hot grant vector (bit0 = m0, bit1 = m1),
  // so grant_o is the state register itself and doubles as state visibility.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GRANT0 = 2'b01,
    ST_GRANT1 = 2'b10
  } arb_state_e;

  // On a tie, grant the master that was not served last.
  function automatic arb_state_e pick_tie(input logic last_served);
    return last_served ? ST_GRANT0 : ST_GRANT1;
  endfunction

endpackage

// File: rtl/rv32im_wb_arbiter_wb_watchdog.sv
// Grant watchdog: counts granted cycles that end without ack/err and flags
// when the count reaches TIMEOUT.
module wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic clear_i,
  input  logic start,
  input  logic tick,
  output logic done
);

  // Width depends only on TIMEOUT, never on the bus width.
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  // Counter: zeroed on grant entry, advances on each uncompleted grant
  // cycle, and holds once it has reached TIMEOUT.
  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (tick && !done) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign done = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/rv32im_wb_arbiter.sv
// Two-master Wishbone arbiter: m0 = instruction fetch, m1 = data memory.
// Round-robin on ties, one-cycle request-to-strobe latency, watchdog-forced
// error on a silent slave, sticky timeout flag.
//
// Handshake: a master holds mX_stb_i high until it sees mX_ack_o or
// mX_err_o (both single-cycle and combinational from the slave). A master
// dropping its strobe while granted aborts the cycle with no response.
module rv32im_wb_arbiter
  import rv32im_wb_arbiter_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = WB_TIMEOUT_DEFAULT
) (
  input  logic                clk_i,
  input  logic                clear_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [WB_SEL_W-1:0] m0_sel_i,
  input  logic [XLEN-3:0]     m0_adr_i,
  input  logic [XLEN-1:0]     m0_dat_i,
  output logic [XLEN-1:0]     m0_dat_o,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [WB_SEL_W-1:0] m1_sel_i,
  input  logic [XLEN-3:0]     m1_adr_i,
  input  logic [XLEN-1:0]     m1_dat_i,
  output logic [XLEN-1:0]     m1_dat_o,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic                s_stb_o,
  output logic                s_cyc_o,
  output logic                s_we_o,
  output logic [WB_SEL_W-1:0] s_sel_o,
  output logic [XLEN-3:0]     s_adr_o,
  output logic [XLEN-1:0]     s_dat_o,
  input  logic [XLEN-1:0]     s_dat_i,
  input  logic                s_ack_i,
  input  logic                s_err_i,
  output logic [1:0]          grant_o,
  output logic                timeout_o
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       timeout_q, timeout_d;

  logic in_grant, gnt_stb;
  logic ev_abort, ev_ack, ev_err, ev_to, finish;
  logic wd_start, wd_tick, wd_done;

  // Completion events of the current grant, in priority order:
  // abort (strobe gone) > ack > err > watchdog timeout.
  assign in_grant = (state_q != ST_IDLE);
  assign gnt_stb  = (state_q == ST_GRANT0) ? m0_stb_i :
                    (state_q == ST_GRANT1) ? m1_stb_i : 1'b0;
  assign ev_abort = in_grant & ~gnt_stb;
  assign ev_ack   = in_grant &  gnt_stb &  s_ack_i;
  assign ev_err   = in_grant &  gnt_stb & ~s_ack_i &  s_err_i;
  assign ev_to    = in_grant &  gnt_stb & ~s_ack_i & ~s_err_i & wd_done;
  assign finish   = ev_abort | ev_ack | ev_err | ev_to;

  assign wd_start = (state_q == ST_IDLE) && (state_d != ST_IDLE);
  assign wd_tick  = in_grant & ~finish;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wb_watchdog (
    .clk_i   (clk_i),
    .clear_i (clear_i),
    .start   (wd_start),
    .tick    (wd_tick),
    .done    (wd_done)
  );

  // State register plus round-robin marker and sticky timeout flag.
  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      state_q   <= ST_IDLE;
      last_q    <= WB_LAST_RESET;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, leave GRANT on any completion.
  // The served master is recorded on every exit (abort included) so a
  // waiting peer always wins the following tie.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    timeout_d = timeout_q | ev_to;
    unique case (state_q)
      ST_IDLE: begin
        if (m0_stb_i && m1_stb_i) state_d = pick_tie(last_q);
        else if (m0_stb_i)        state_d = ST_GRANT0;
        else if (m1_stb_i)        state_d = ST_GRANT1;
      end
      ST_GRANT0: begin
        if (finish) begin
          state_d = ST_IDLE;
          last_d  = 1'b0;
        end
      end
      ST_GRANT1: begin
        if (finish) begin
          state_d = ST_IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: mux the granted master onto the slave and route the
  // slave response back to that master only; the timeout cycle drops the
  // slave cycle and substitutes a local error.
  always_comb begin
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
    grant_o  = state_q;
    unique case (state_q)
      ST_GRANT0: begin
        s_cyc_o  = ~ev_to;
        s_stb_o  = m0_stb_i & ~ev_to;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = ev_ack;
        m0_err_o = ev_err | ev_to;
      end
      ST_GRANT1: begin
        s_cyc_o  = ~ev_to;
        s_stb_o  = m1_stb_i & ~ev_to;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = ev_ack;
        m1_err_o = ev_err | ev_to;
      end
      default: ;
    endcase
  end

  assign timeout_o = timeout_q;

endmodule
